tstate_seq: RTL and testbench

//  T-state ring sequencer for the SAP-2 control unit. Consumes the clken/clken2

---
 rtl/tstate_seq.sv | 166 ++++++++++++++++
 tb/tb_tstate_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tstate_seq.sv
// ---------------------------------------------------------------------------
// tstate_seq -- T-state ring sequencer for the SAP-2 control unit.
//
// Turns the clken/clken2 strobes from the clock-enable divider into a one-hot
// T-state bus that the control matrix decodes. The sequencer can free-run,
// single-step, halt, or end an instruction early (nxt). It also counts
// instruction starts.
//
// Parameters
//   NSTATES  ring length, i.e. number of T-states (min 3)
//   CNTW     width of the instruction-start counter
//
// Ports
//   sysclk       in   system clock; every state change happens on its rising edge
//   reset_n      in   asynchronous active-low reset
//   clken        in   advance strobe, 1 sysclk wide
//   clken2       in   mid-period strobe; never coincides with clken
//   run          in   level; 1 = free-run
//   step         in   single-step request, level-sampled on every edge
//   hlt          in   halt request; sampled when clken2 is high
//   nxt          in   end the instruction early; sampled when clken is high
//   t            out  one-hot T-state; bit0 = T1
//   tnum         out  binary index of t; 0 = T1
//   halted       out  1 while in the HALTED mode
//   instr_start  out  1-cycle pulse on the edge after the ring enters T1
//   step_done    out  1-cycle pulse on the edge after a stepped advance
//   icount       out  count of instr_start pulses (wraps)
// ---------------------------------------------------------------------------
module tstate_seq #(
  parameter int unsigned NSTATES = 6,
  parameter int unsigned CNTW    = 16,
  localparam int unsigned TW     = $clog2(NSTATES)
) (
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic               clken2,
  input  logic               run,
  input  logic               step,
  input  logic               hlt,
  input  logic               nxt,
  output logic [NSTATES-1:0] t,
  output logic [TW-1:0]      tnum,
  output logic               halted,
  output logic               instr_start,
  output logic               step_done,
  output logic [CNTW-1:0]    icount
);

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    HALTED
  } mode_e;

  localparam logic [NSTATES-1:0] T1 = NSTATES'(1);

  mode_e              mode_q, mode_d;
  logic [NSTATES-1:0] t_q, t_d;
  logic [TW-1:0]      tnum_q, tnum_d;
  logic               step_pend_q, step_pend_d;
  logic               halt_req_q, halt_req_d;
  logic               enter_t1_q, enter_t1_d;
  logic               stepped_q, stepped_d;
  logic               halted_q, halted_d;
  logic               instr_start_q, instr_start_d;
  logic               step_done_q, step_done_d;
  logic [CNTW-1:0]    icount_q, icount_d;

  logic               advance;
  logic               t_legal;

  // One-hot test: non-zero with exactly one bit set.
  assign t_legal = (t_q != '0) && ((t_q & (t_q - T1)) == '0);

  always_comb begin
    mode_d      = mode_q;
    t_d         = t_q;
    tnum_d      = tnum_q;
    step_pend_d = step_pend_q | (step && (mode_q != HALTED));
    halt_req_d  = halt_req_q | (clken2 && hlt);
    enter_t1_d  = 1'b0;
    stepped_d   = 1'b0;
    advance     = 1'b0;

    if (clken) begin
      // First matching rule wins; HALTED is only left through reset.
      if (mode_q == HALTED) begin
        mode_d = HALTED;
      end else if (halt_req_q) begin
        mode_d = HALTED;
      end else if (mode_q == RUNNING) begin
        if (run) begin
          advance = 1'b1;
        end else begin
          mode_d = STOPPED;
        end
      end else if (run) begin
        // Run takes over from a pending step without reporting step_done.
        mode_d      = RUNNING;
        advance     = 1'b1;
        step_pend_d = 1'b0;
      end else if (step_pend_q) begin
        advance     = 1'b1;
        step_pend_d = 1'b0;
        stepped_d   = 1'b1;
      end

      if (!t_legal) begin
        t_d    = T1;
        tnum_d = '0;
      end else if (advance) begin
        if (nxt || t_q[NSTATES-1]) begin
          t_d        = T1;
          tnum_d     = '0;
          enter_t1_d = 1'b1;
        end else begin
          t_d    = {t_q[NSTATES-2:0], 1'b0};
          tnum_d = tnum_q + TW'(1);
        end
      end
    end

    halted_d      = (mode_d == HALTED);
    // Start/step reporting lags the advancing edge by one sysclk.
    instr_start_d = enter_t1_q;
    step_done_d   = stepped_q;
    icount_d      = icount_q + CNTW'(enter_t1_q);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= STOPPED;
      t_q           <= T1;
      tnum_q        <= '0;
      step_pend_q   <= 1'b0;
      halt_req_q    <= 1'b0;
      enter_t1_q    <= 1'b0;
      stepped_q     <= 1'b0;
      halted_q      <= 1'b0;
      instr_start_q <= 1'b0;
      step_done_q   <= 1'b0;
      icount_q      <= '0;
    end else begin
      mode_q        <= mode_d;
      t_q           <= t_d;
      tnum_q        <= tnum_d;
      step_pend_q   <= step_pend_d;
      halt_req_q    <= halt_req_d;
      enter_t1_q    <= enter_t1_d;
      stepped_q     <= stepped_d;
      halted_q      <= halted_d;
      instr_start_q <= instr_start_d;
      step_done_q   <= step_done_d;
      icount_q      <= icount_d;
    end
  end

  assign t           = t_q;
  assign tnum        = tnum_q;
  assign halted      = halted_q;
  assign instr_start = instr_start_q;
  assign step_done   = step_done_q;
  assign icount      = icount_q;

endmodule

// File: tb/tb_tstate_seq.sv
// ---------------------------------------------------------------------------
// tb_tstate_seq -- self-checking bench for tstate_seq (NSTATES=6, divider of 8).
// A second instance with a 4-bit counter exercises the icount wrap.
// ---------------------------------------------------------------------------
module tb_tstate_seq;

  localparam int NS  = 6;
  localparam int DIV = 8;

  logic sysclk = 1'b0;
  logic reset_n, clken, clken2, run, step, hlt, nxt;

  logic [NS-1:0] t,  t4;
  logic [2:0]    tnum, tnum4;
  logic          halted, instr_start, step_done;
  logic          halted4, instr_start4, step_done4;
  logic [15:0]   icount;
  logic [3:0]    icount4;

  tstate_seq #(.NSTATES(NS), .CNTW(16)) u_dut (
    .sysclk(sysclk), .reset_n(reset_n), .clken(clken), .clken2(clken2),
    .run(run), .step(step), .hlt(hlt), .nxt(nxt),
    .t(t), .tnum(tnum), .halted(halted), .instr_start(instr_start),
    .step_done(step_done), .icount(icount)
  );

  tstate_seq #(.NSTATES(NS), .CNTW(4)) u_dut4 (
    .sysclk(sysclk), .reset_n(reset_n), .clken(clken), .clken2(clken2),
    .run(run), .step(step), .hlt(hlt), .nxt(nxt),
    .t(t4), .tnum(tnum4), .halted(halted4), .instr_start(instr_start4),
    .step_done(step_done4), .icount(icount4)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  int div      = 0;

  // Reference model: ring position as an integer, mode as 0=stop 1=run 2=halt.
  int          m_idx, m_mode;
  bit          m_pend, m_hreq, m_start_due, m_step_due, m_instr, m_sd;
  int unsigned m_count;

  task automatic model_reset();
    m_idx = 0; m_mode = 0; m_pend = 0; m_hreq = 0;
    m_start_due = 0; m_step_due = 0; m_instr = 0; m_sd = 0; m_count = 0;
  endtask

  task automatic model_step();
    bit pend_n, hreq_n, adv;
    m_instr = m_start_due;
    m_sd    = m_step_due;
    if (m_start_due) m_count++;
    m_start_due = 0;
    m_step_due  = 0;
    pend_n = m_pend | (step && m_mode != 2);
    hreq_n = m_hreq | (clken2 && hlt);
    adv = 0;
    if (clken) begin
      if (m_mode == 2) begin
        adv = 0;
      end else if (m_hreq) begin
        m_mode = 2;
      end else if (m_mode == 1) begin
        if (run) adv = 1; else m_mode = 0;
      end else if (run) begin
        m_mode = 1; adv = 1; pend_n = 0;
      end else if (m_pend) begin
        adv = 1; pend_n = 0; m_step_due = 1;
      end
    end
    if (adv) begin
      if (nxt || m_idx == NS - 1) begin
        m_idx = 0;
        m_start_due = 1;
      end else begin
        m_idx++;
      end
    end
    m_pend = pend_n;
    m_hreq = hreq_n;
  endtask

  function automatic logic [41:0] expected();
    logic [NS-1:0] one;
    one = NS'(1) << m_idx;
    return {one, 3'(m_idx), (m_mode == 2), m_instr, m_sd, 16'(m_count),
            one, 4'(m_count)};
  endfunction

  function automatic logic [41:0] observed();
    return {t, tnum, halted, instr_start, step_done, icount, t4, icount4};
  endfunction

  // One sysclk: drive the divider strobes, clock, update model, settle.
  task automatic cycle();
    clken  = (div == DIV - 1);
    clken2 = (div == DIV / 2 - 1);
    div    = (div + 1) % DIV;
    @(posedge sysclk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    run = 0; step = 0; hlt = 0; nxt = 0; clken = 0; clken2 = 0;
    reset_n = 0;
    repeat (3) @(posedge sysclk);
    #1;
    model_reset();
    n_checks++;
    if (observed() !== 42'({6'b000001, 3'd0, 3'b000, 16'd0, 6'b000001, 4'd0}))
      $display("FAIL reset: got %h want %h", observed(),
               42'({6'b000001, 3'd0, 3'b000, 16'd0, 6'b000001, 4'd0}));
    else n_pass++;
    reset_n = 1;
    div = 0;
  endtask

  task automatic test_run_wrap();
    run = 1;
    for (int p = 0; p < 13; p++) begin
      for (int c = 0; c < DIV; c++) begin
        cycle();
        n_checks++;
        if (observed() !== expected())
          $display("FAIL run_wrap p%0d c%0d: got %h want %h", p, c, observed(), expected());
        else n_pass++;
        if (p == 12 && c == 0) begin
          n_checks++;
          if (icount !== 16'd2 || t !== 6'b000001 || instr_start !== 1'b1)
            $display("FAIL run_wrap_count: icount=%0d t=%b is=%b want 2 000001 1",
                     icount, t, instr_start);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_nxt();
    logic [NS-1:0] prev_t;
    bit early = 0;
    run = 1;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < DIV; c++) begin
        nxt = (m_idx == 3);
        prev_t = t;
        cycle();
        if (prev_t == 6'b001000 && t == 6'b000001) early = 1;
        n_checks++;
        if (observed() !== expected())
          $display("FAIL nxt p%0d c%0d: got %h want %h", p, c, observed(), expected());
        else n_pass++;
      end
    end
    nxt = 0;
    n_checks++;
    if (!early) $display("FAIL nxt_t4_to_t1: got no T4->T1 jump want one");
    else n_pass++;
  endtask

  task automatic test_step();
    int sd_cnt;
    run = 0;
    for (int c = 0; c < DIV; c++) cycle();
    for (int k = 0; k < 2; k++) begin
      sd_cnt = 0;
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < DIV; c++) begin
          // first round: one pulse; second round: two pulses in one period
          step = (p == 0) && (c == 2 || (k == 1 && c == 4));
          cycle();
          if (step_done) sd_cnt++;
          n_checks++;
          if (observed() !== expected())
            $display("FAIL step k%0d p%0d c%0d: got %h want %h", k, p, c, observed(), expected());
          else n_pass++;
        end
      end
      step = 0;
      n_checks++;
      if (sd_cnt !== 1) $display("FAIL step_done_count k%0d: got %0d want 1", k, sd_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_run_over_step();
    int sd_cnt = 0;
    run = 0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < DIV; c++) begin
        step = (p == 0 && c == 2);
        if (p == 0 && c == 5) run = 1;
        cycle();
        if (step_done) sd_cnt++;
        n_checks++;
        if (observed() !== expected())
          $display("FAIL run_over_step p%0d c%0d: got %h want %h", p, c, observed(), expected());
        else n_pass++;
      end
    end
    step = 0;
    n_checks++;
    if (sd_cnt !== 0) $display("FAIL run_over_step_sd: got %0d want 0", sd_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    bit wrapped = 0;
    logic [3:0] prev4;
    for (int p = 0; p < 120; p++) begin
      run = ($urandom_range(3, 0) != 0);
      for (int c = 0; c < DIV; c++) begin
        step = ($urandom_range(15, 0) == 0);
        nxt  = ($urandom_range(3, 0) == 0);
        prev4 = icount4;
        cycle();
        if (prev4 == 4'd15 && icount4 == 4'd0) wrapped = 1;
        n_checks++;
        if (observed() !== expected())
          $display("FAIL random p%0d c%0d: got %h want %h", p, c, observed(), expected());
        else n_pass++;
      end
    end
    step = 0; nxt = 0;
    n_checks++;
    if (!wrapped) $display("FAIL icount4_wrap: got no 15->0 wrap want one");
    else n_pass++;
  endtask

  task automatic test_halt();
    run = 1;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < DIV; c++) begin
        hlt = (m_idx == 3 && c == DIV / 2 - 1);
        cycle();
        n_checks++;
        if (observed() !== expected())
          $display("FAIL halt_entry p%0d c%0d: got %h want %h", p, c, observed(), expected());
        else n_pass++;
      end
    end
    hlt = 0;
    for (int p = 0; p < 10; p++) begin
      run = $urandom_range(1, 0);
      for (int c = 0; c < DIV; c++) begin
        step = ($urandom_range(3, 0) == 0);
        cycle();
        n_checks++;
        if (observed() !== expected())
          $display("FAIL halt_hold p%0d c%0d: got %h want %h", p, c, observed(), expected());
        else n_pass++;
      end
    end
    step = 0;
    n_checks++;
    if (halted !== 1'b1 || t !== 6'b001000)
      $display("FAIL halt_state: halted=%b t=%b want 1 001000", halted, t);
    else n_pass++;
    // Asynchronous reset between clock edges.
    #2 reset_n = 0;
    #1;
    n_checks++;
    if (t !== 6'b000001 || halted !== 1'b0 || icount !== 16'd0)
      $display("FAIL async_reset: t=%b halted=%b icount=%0d want 000001 0 0",
               t, halted, icount);
    else n_pass++;
    model_reset();
    @(posedge sysclk);
    #1;
    reset_n = 1;
    div = 0;
    for (int c = 0; c < DIV; c++) begin
      cycle();
      n_checks++;
      if (observed() !== expected())
        $display("FAIL post_reset c%0d: got %h want %h", c, observed(), expected());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_run_wrap();
    test_nxt();
    test_step();
    test_run_over_step();
    test_random();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
